// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared states, quarter phases and control-word layout for codec_cfg
package codec_cfg_pkg;
   localparam logic [2:0] S_PWRUP = 3'd0,
                          S_START = 3'd1,
                          S_BYTE  = 3'd2,
                          S_ACK   = 3'd3,
                          S_STOP  = 3'd4,
                          S_GAP   = 3'd5,
                          S_DONE  = 3'd6,
                          S_ERR   = 3'd7;
   localparam logic [1:0] Q0 = 2'd0,
                          Q1 = 2'd1,
                          Q2 = 2'd2,
                          Q3 = 2'd3;
   localparam int REG_W  = 7;
   localparam int DATA_W = 9;
   localparam int WORD_W = REG_W + DATA_W;
   localparam int IDX_W  = 4;

   // byte n of a frame: device address with write bit, then the control word high/low
   function automatic logic [7:0] frame_byte(input logic [1:0] n, input logic [6:0] addr,
                                             input logic [WORD_W-1:0] w);
      return (n == 2'd0) ? {addr, 1'b0} : (n == 2'd1) ? w[WORD_W-1:8] : w[7:0];
   endfunction
endpackage

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom: WM8731 power-up control words, {reg[6:0], data[8:0]}
module codec_cfg_rom
   import codec_cfg_pkg::*;
(
   input  logic [IDX_W-1:0]  i_idx,
   output logic [WORD_W-1:0] o_word
);
   always_comb
      case (i_idx)
         4'd0:    o_word = 16'h1E00;
         4'd1:    o_word = 16'h0C10;
         4'd2:    o_word = 16'h0017;
         4'd3:    o_word = 16'h0217;
         4'd4:    o_word = 16'h0479;
         4'd5:    o_word = 16'h0679;
         4'd6:    o_word = 16'h0812;
         4'd7:    o_word = 16'h0A00;
         4'd8:    o_word = 16'h0E02;
         4'd9:    o_word = 16'h1201;
         default: o_word = 16'h0000;
      endcase
endmodule

// File: rtl/codec_cfg.sv
// codec_cfg: power-up I2C configuration sequencer for the external audio codec
module codec_cfg
   import codec_cfg_pkg::*;
#(
   parameter int         QDIV      = 60,
   parameter int         PWRUP_DLY = 24000,
   parameter logic [6:0] I2C_ADDR  = 7'h1A,
   parameter int         NREG      = 10,
   parameter int         RETRY     = 3
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic start,
   input  logic sda_in,
   output logic scl_oe,
   output logic sda_oe,
   output logic busy,
   output logic done,
   output logic err
);
   localparam int CW = $clog2((PWRUP_DLY > QDIV ? PWRUP_DLY : QDIV) + 1);
   localparam int RW = $clog2(RETRY + 2);

   logic [2:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic [1:0]        r_q;
   logic [2:0]        r_bit;
   logic [1:0]        r_byte;
   logic [IDX_W-1:0]  r_idx;
   logic [RW-1:0]     r_retry;
   logic [1:0]        r_sync;
   logic              r_nak;
   logic [CW-1:0]     w_lim;
   logic              w_tick;
   logic [WORD_W-1:0] w_word;
   logic [7:0]        w_byte;
   logic              w_bit;

   codec_cfg_rom u_rom (
      .i_idx  (r_idx),
      .o_word (w_word)
   );

   // one shared counter times both the power-up delay and the SCL quarters
   always_comb begin
      w_lim  = (r_state == S_PWRUP) ? CW'(PWRUP_DLY - 1) : CW'(QDIV - 1);
      w_tick = r_cnt == w_lim;
      w_byte = frame_byte(r_byte, I2C_ADDR, w_word);
      w_bit  = w_byte[~r_bit];
   end

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         r_state <= S_PWRUP;
         r_cnt   <= '0;
         r_q     <= Q0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_idx   <= '0;
         r_retry <= '0;
         r_sync  <= 2'b11;
         r_nak   <= 1'b0;
         scl_oe  <= 1'b0;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], sda_in};
         r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick) r_q <= r_q + 1'b1;
         case (r_state)
            S_PWRUP: if (w_tick) begin
               r_state <= S_START;
               r_q     <= Q0;
               busy    <= 1'b1;
            end
            S_START: if (w_tick) begin
               if (r_q == Q0) begin
                  sda_oe <= 1'b1;
                  r_byte <= '0;
                  r_nak  <= 1'b0;
               end
               if (r_q == Q3) begin
                  scl_oe  <= 1'b1;
                  r_state <= S_BYTE;
               end
            end
            S_BYTE: if (w_tick) begin
               if (r_q == Q0) sda_oe <= ~w_bit;
               if (r_q == Q1) scl_oe <= 1'b0;
               if (r_q == Q3) begin
                  scl_oe <= 1'b1;
                  r_bit  <= r_bit + 1'b1;
                  if (r_bit == 3'd7) r_state <= S_ACK;
               end
            end
            S_ACK: if (w_tick) begin
               if (r_q == Q0) sda_oe <= 1'b0;
               if (r_q == Q1) scl_oe <= 1'b0;
               if (r_q == Q2) r_nak <= r_sync[1];
               if (r_q == Q3) begin
                  scl_oe  <= 1'b1;
                  r_byte  <= r_byte + 1'b1;
                  r_state <= (r_nak || r_byte == 2'd2) ? S_STOP : S_BYTE;
               end
            end
            S_STOP: if (w_tick) begin
               if (r_q == Q0) sda_oe <= 1'b1;
               if (r_q == Q1) scl_oe <= 1'b0;
               if (r_q == Q2) sda_oe <= 1'b0;
               if (r_q == Q3) r_state <= S_GAP;
            end
            S_GAP: if (w_tick && r_q == Q3) begin
               if (r_nak) begin
                  if (r_retry == RW'(RETRY)) begin
                     r_state <= S_ERR;
                     err     <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     r_retry <= r_retry + 1'b1;
                     r_state <= S_START;
                  end
               end else begin
                  r_retry <= '0;
                  if (r_idx == IDX_W'(NREG - 1)) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= S_START;
                  end
               end
            end
            S_DONE, S_ERR: if (start) begin
               r_state <= S_START;
               r_cnt   <= '0;
               r_q     <= Q0;
               r_idx   <= '0;
               r_retry <= '0;
               done    <= 1'b0;
               err     <= 1'b0;
               busy    <= 1'b1;
            end
         endcase
      end
endmodule

// File: tb/tb_codec_cfg.sv
// tb_codec_cfg: directed checks of codec_cfg against a behavioural I2C slave
module tb_codec_cfg;
   localparam int QDIV      = 4;
   localparam int PWRUP_DLY = 100;
   localparam int NREG      = 10;
   localparam int RETRY     = 3;
   localparam int BIT_T     = 4 * QDIV;
   localparam int FRAME_T   = 30 * BIT_T;

   logic CLK = 1'b0, RESET_N = 1'b1, start = 1'b0;
   logic scl_oe, sda_oe, busy, done, err;
   logic ack_drv = 1'b0;
   logic scl, sda;
   int   checks = 0, errors = 0, cyc = 0;

   logic [15:0] tbl [NREG] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479,
                               16'h0679, 16'h0812, 16'h0A00, 16'h0E02, 16'h1201};
   logic [7:0] rx[$];
   logic [7:0] exp_q[$];
   logic [7:0] sh = 8'h00;
   logic       in_frame = 1'b0;
   logic       nak_addr_all = 1'b0;
   int         starts = 0, bcnt = 0, nbyte = 0, nak_frame = -1, nak_byte = -1;

   assign scl = ~scl_oe;
   assign sda = ~(sda_oe | ack_drv);

   always #5 CLK = ~CLK;

   codec_cfg #(
      .QDIV(QDIV), .PWRUP_DLY(PWRUP_DLY), .I2C_ADDR(7'h1A), .NREG(NREG), .RETRY(RETRY)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .start(start), .sda_in(sda),
      .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy), .done(done), .err(err)
   );

   always @(negedge sda) if (scl) begin
      in_frame = 1'b1;
      bcnt     = 0;
      nbyte    = 0;
      ack_drv  = 1'b0;
      starts++;
   end
   always @(posedge sda) if (scl) in_frame = 1'b0;
   always @(posedge scl) if (in_frame) begin
      if (bcnt < 8) sh = {sh[6:0], sda};
      bcnt++;
   end
   always @(negedge scl) if (in_frame) begin
      if (bcnt == 8) begin
         rx.push_back(sh);
         ack_drv = !(nak_addr_all && nbyte == 0) && !(starts - 1 == nak_frame && nbyte == nak_byte);
         nbyte++;
      end else if (bcnt == 9) begin
         ack_drv = 1'b0;
         bcnt    = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1 cyc++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_sda(input int lim, output logic seen);
      int n = 0;
      seen = 1'b0;
      while (!sda_oe && n < lim) begin
         tick();
         seen |= scl_oe;
         n++;
      end
   endtask

   task automatic wait_end(input int lim);
      int n = 0;
      while (!(done || err) && n < lim) begin
         tick();
         n++;
      end
   endtask

   task automatic scl_rise(output int c);
      logic prev = scl;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (scl && !prev) break;
         prev = scl;
      end
      c = cyc;
   endtask

   task automatic add_entry(input int e);
      exp_q.push_back(8'h34);
      exp_q.push_back(tbl[e][15:8]);
      exp_q.push_back(tbl[e][7:0]);
   endtask

   task automatic compare_rx(input string tag);
      check($sformatf("%s_len", tag), rx.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), i < rx.size() ? 32'(rx[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
   endtask

   initial begin
      int   t0, c1, c2;
      logic seen;
      #2 RESET_N = 1'b0;
      #1 check("rst_out", {scl_oe, sda_oe, busy, done, err}, 5'b0);
      tick();
      tick();
      rx.delete();
      starts  = 0;
      RESET_N = 1'b1;
      t0      = cyc;
      wait_sda(200, seen);
      check("pwrup_scl_idle", seen, 0);
      check("pwrup_first_sda", cyc - t0, PWRUP_DLY + QDIV);
      check("busy_in_frame", busy, 1);
      scl_rise(c1);
      scl_rise(c2);
      check("scl_period", c2 - c1, BIT_T);
      wait_end(6000);
      check("run1_time", cyc - t0, PWRUP_DLY + NREG * FRAME_T);
      check("run1_flags", {done, busy, err}, 3'b100);
      exp_q.delete();
      for (int e = 0; e < NREG; e++) add_entry(e);
      compare_rx("run1");
      check("run1_frames", starts, NREG);

      rx.delete();
      starts    = 0;
      nak_frame = 3;
      nak_byte  = 2;
      pulse_start();
      t0 = cyc;
      check("start_clears_done", {done, busy}, 2'b01);
      wait_sda(20, seen);
      check("restart_no_pwrup", cyc - t0, QDIV);
      repeat (200) tick();
      pulse_start();
      check("busy_start_ignored", {done, busy, err}, 3'b010);
      wait_end(7000);
      check("run2_time", cyc - t0, (NREG + 1) * FRAME_T);
      check("run2_flags", {done, busy, err}, 3'b100);
      exp_q.delete();
      for (int e = 0; e < NREG; e++) begin
         add_entry(e);
         if (e == 3) add_entry(e);
      end
      compare_rx("run2");
      check("run2_frames", starts, NREG + 1);

      rx.delete();
      starts       = 0;
      nak_frame    = -1;
      nak_addr_all = 1'b1;
      pulse_start();
      t0 = cyc;
      wait_end(2000);
      check("run3_time", cyc - t0, (RETRY + 1) * 12 * BIT_T);
      check("run3_flags", {done, busy, err, scl_oe, sda_oe}, 5'b00100);
      check("run3_frames", starts, RETRY + 1);
      exp_q.delete();
      repeat (RETRY + 1) exp_q.push_back(8'h34);
      compare_rx("run3");

      nak_addr_all = 1'b0;
      pulse_start();
      check("err_cleared", {err, busy}, 2'b01);
      repeat (33) tick();
      check("pre_rst", {scl_oe, sda_oe, busy}, 3'b111);
      #3 RESET_N = 1'b0;
      #1 check("mid_rst_out", {scl_oe, sda_oe, busy, done, err}, 5'b0);
      tick();
      tick();
      rx.delete();
      starts  = 0;
      RESET_N = 1'b1;
      t0      = cyc;
      wait_sda(200, seen);
      check("rst_restart_sda", cyc - t0, PWRUP_DLY + QDIV);
      wait_end(6000);
      check("run4_time", cyc - t0, PWRUP_DLY + NREG * FRAME_T);
      check("run4_flags", {done, busy, err}, 3'b100);
      exp_q.delete();
      for (int e = 0; e < NREG; e++) add_entry(e);
      compare_rx("run4");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
